midori_ct_unmask_collect: RTL and testbench
===========================================

Name: midori_ct_unmask_collect

Overview:
- Output-side companion to the Midori64 shared-core input wrapper.
- Sequences one encryption run: accepts a request, issues `start` to `midori_shared_top`, then waits for `done`.
- On `done`, captures the three ciphertext shares and XOR-recombines them into the unmasked ciphertext.
- Optionally compares the result with an expected value and presents it on a valid/ready result port. Keeps run and error statistics for the non-uniform-input simulation bench.

Parameters:
- TIMEOUT_CYCLES, 128, maximum WAIT cycles before a run is declared hung.
- CNT_W, 16, width of the saturating run and error counters.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- req, in, 1, request one encryption run; sampled only in IDLE.
- exp_valid, in, 1, compare enable; sampled together with req.
- exp_ct, in, 64, expected unmasked ciphertext; sampled together with req.
- core_start, out, 1, single-cycle start pulse to the shared core.
- core_done, in, 1, done from the shared core.
- ct_share_1, in, 64, ciphertext share 1.
- ct_share_2, in, 64, ciphertext share 2.
- ct_share_3, in, 64, ciphertext share 3.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts the result.
- res_ct, out, 64, ct_share_1 ^ ct_share_2 ^ ct_share_3 captured at done; 0 on timeout.
- res_match, out, 1, 1 iff compare was enabled, no timeout occurred, and res_ct == exp_ct.
- res_timeout, out, 1, run ended by timeout.
- busy, out, 1, 1 in every state except IDLE.
- run_count, out, CNT_W, number of completed runs (done or timeout); saturating.
- err_count, out, CNT_W, number of mismatches plus timeouts; saturating.

Behaviour:
- Reset (sync, active-high): state=IDLE. All outputs 0, counters 0, latched exp_ct/exp_valid 0. Reset wins over every other event.
- FSM states: IDLE, ARM, START, WAIT, HOLD.
- IDLE: if req=1, latch exp_ct and exp_valid, then go to ARM. core_done is ignored in IDLE.
- ARM: one cycle, no outputs. Gives the wrapper's registered plaintext shares time to settle. Go to START.
- START: core_start=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT: the wait counter increments each cycle.
  - If core_done=1: register res_ct = XOR of the three shares sampled this cycle. Set res_match per its definition, res_timeout=0, go to HOLD.
  - Else if wait counter == TIMEOUT_CYCLES-1: res_ct=0, res_match=0, res_timeout=1, go to HOLD.
  - If core_done and terminal count occur in the same cycle, done wins.
- HOLD: res_valid=1, and res_ct/res_match/res_timeout stay stable until res_valid && res_ready. On handshake, go to IDLE and res_valid=0 next cycle.
- Latency:
  - req accepted at cycle t → core_start at t+2.
  - core_done at cycle d → res_valid at d+1.
  - Earliest next req is accepted in the cycle after the handshake.
- req outside IDLE is ignored (not queued). core_done outside WAIT is ignored.
- Counters:
  - run_count increments on every entry to HOLD.
  - err_count increments on entry to HOLD if timeout, or if (exp_valid latched and mismatch).
  - Both counters saturate at all-ones.
- Outputs are registered; no combinational path from core inputs to res_*.

Decomposition:
- Package midori_ctrl_pkg holds:
  - FSM state enum/encoding (IDLE, ARM, START, WAIT, HOLD);
  - default TIMEOUT_CYCLES;
  - CNT_W;
  - Midori64 width constants (64-bit state, 128-bit key, 3 shares).
- One sub-module: sat_counter (parameter width W; ports clk, reset, inc, count), instantiated twice for run_count and err_count.

Test Plan:
- Basic run:
  - Stimulus: req with exp_valid=1, exp_ct=0x66bcdc6270d901cd; shares 0x0123456789abcdef, 0xfedcba9876543210, 0x9943239d8f26fe32; core_done 20 cycles after core_start.
  - Response: core_start at t+2; res_ct=0x66bcdc6270d901cd; res_match=1; run_count=1; err_count=0.
- Mismatch:
  - Stimulus: same shares, exp_ct=0x66bcdc6270d901cc.
  - Response: res_match=0, res_timeout=0, err_count increments by 1.
- Compare disabled:
  - Stimulus: exp_valid=0.
  - Response: res_match=0, err_count unchanged, res_ct correct.
- Timeout:
  - Stimulus: core_done held 0.
  - Response: res_valid exactly TIMEOUT_CYCLES+1 cycles after core_start; res_timeout=1, res_ct=0; err_count+1, run_count+1.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles, with req pulsed during HOLD.
  - Response: res_valid and res_ct stable; req ignored; no extra core_start; after the handshake, a new req gives core_start 2 cycles later.
- Reset and corner cases:
  - Stimulus: reset asserted in WAIT, then core_done pulsed.
  - Response: all outputs 0 next cycle; the late done is ignored.
  - Stimulus: core_done asserted on the terminal-count cycle.
  - Response: res_timeout=0 and res_ct equals the XOR of the shares.

Source files
------------

// File: rtl/midori_ctrl_pkg.sv
// Shared constants and types for the Midori64 shared-core control wrappers.
// FSM encoding, default sizing and the share recombination helper live here.
package midori_ctrl_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 128;
  localparam int DEF_CNT_W          = 16;
  localparam int STATE_W            = 64;
  localparam int KEY_W              = 128;
  localparam int N_SHARES           = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } ctrl_state_t;

  function automatic logic [STATE_W-1:0] unmask(
    input logic [N_SHARES-1:0][STATE_W-1:0] shares
  );
    logic [STATE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_SHARES; i++) begin
      acc = acc ^ shares[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/midori_ct_unmask_collect_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Synchronous active-high reset clears to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/midori_ct_unmask_collect.sv
// Runs one shared-core encryption per request, recombines the ciphertext shares,
// optionally checks against an expected value and holds the result until accepted.
module midori_ct_unmask_collect
  import midori_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             exp_valid,
  input  logic [63:0]      exp_ct,
  output logic             core_start,
  input  logic             core_done,
  input  logic [63:0]      ct_share_1,
  input  logic [63:0]      ct_share_2,
  input  logic [63:0]      ct_share_3,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_ct,
  output logic             res_match,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int                WC_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WC_W-1:0]   TC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t          r_state;
  ctrl_state_t          w_next;
  logic [WC_W-1:0]      r_wait_cnt;
  logic [STATE_W-1:0]   r_exp_ct;
  logic                 r_exp_vld;
  logic [STATE_W-1:0]   r_res_ct;
  logic                 r_res_match;
  logic                 r_res_timeout;
  logic [STATE_W-1:0]   w_ct;
  logic                 w_tc;
  logic                 w_in_wait;
  logic                 w_run_inc;
  logic                 w_err_inc;

  assign w_ct      = unmask({ct_share_3, ct_share_2, ct_share_1});
  assign w_tc      = (r_wait_cnt == TC_LAST);
  assign w_in_wait = (r_state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req) w_next = ST_ARM;
      ST_ARM:   w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (core_done || w_tc) w_next = ST_HOLD;
      ST_HOLD:  if (res_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // core_done takes priority over the terminal count in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_exp_ct      <= '0;
      r_exp_vld     <= 1'b0;
      r_res_ct      <= '0;
      r_res_match   <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_exp_ct  <= exp_ct;
            r_exp_vld <= exp_valid;
          end
        end
        ST_START: r_wait_cnt <= '0;
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WC_W'(1);
          if (core_done) begin
            r_res_ct      <= w_ct;
            r_res_match   <= r_exp_vld && (w_ct == r_exp_ct);
            r_res_timeout <= 1'b0;
          end else if (w_tc) begin
            r_res_ct      <= '0;
            r_res_match   <= 1'b0;
            r_res_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_run_inc = w_in_wait && (core_done || w_tc);
  assign w_err_inc = w_in_wait &&
                     (core_done ? (r_exp_vld && (w_ct != r_exp_ct)) : w_tc);

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_run_inc),
    .count (run_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_inc),
    .count (err_count)
  );

  assign core_start  = (r_state == ST_START);
  assign busy        = (r_state != ST_IDLE);
  assign res_valid   = (r_state == ST_HOLD);
  assign res_ct      = r_res_ct;
  assign res_match   = r_res_match;
  assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_midori_ct_unmask_collect.sv
// Directed bench for midori_ct_unmask_collect with hand-computed expectations.
module tb_midori_ct_unmask_collect;

  localparam logic [63:0] SH1   = 64'h0123456789abcdef;
  localparam logic [63:0] SH2   = 64'hfedcba9876543210;
  localparam logic [63:0] SH3   = 64'h9943239d8f26fe32;
  localparam logic [63:0] CT_OK = 64'h66bcdc6270d901cd;
  localparam logic [63:0] CT_BAD = 64'h66bcdc6270d901cc;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        exp_valid;
  logic [63:0] exp_ct;
  logic        core_start;
  logic        core_done;
  logic [63:0] ct_share_1, ct_share_2, ct_share_3;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_ct;
  logic        res_match;
  logic        res_timeout;
  logic        busy;
  logic [15:0] run_count;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_runs = 0;
  int exp_errs = 0;

  midori_ct_unmask_collect dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .exp_valid   (exp_valid),
    .exp_ct      (exp_ct),
    .core_start  (core_start),
    .core_done   (core_done),
    .ct_share_1  (ct_share_1),
    .ct_share_2  (ct_share_2),
    .ct_share_3  (ct_share_3),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ct      (res_ct),
    .res_match   (res_match),
    .res_timeout (res_timeout),
    .busy        (busy),
    .run_count   (run_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the START cycle (t+2 after acceptance).
  task automatic start_run(input logic ev, input logic [63:0] ect);
    req = 1'b1; exp_valid = ev; exp_ct = ect;
    tick();
    req = 1'b0; exp_valid = 1'b0; exp_ct = '0;
    chk("arm_no_start", core_start, 1'b0);
    tick();
    chk("start_at_t2", core_start, 1'b1);
  endtask

  // Pulses core_done n cycles after the START cycle, then samples one cycle later.
  task automatic done_after(input int n);
    for (int i = 0; i < n; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_valid_low", res_valid, 1'b0);
    chk("hs_idle", busy, 1'b0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_runs"}, run_count, exp_runs);
    chk({tag, "_errs"}, err_count, exp_errs);
  endtask

  initial begin
    int  cyc;
    logic stable;
    logic [63:0] held_ct;

    reset = 1'b1; req = 1'b0; exp_valid = 1'b0; exp_ct = '0;
    core_done = 1'b0; res_ready = 1'b0;
    ct_share_1 = SH1; ct_share_2 = SH2; ct_share_3 = SH3;
    tick(); tick();
    reset = 1'b0;
    chk("rst_start", core_start, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_ct", res_ct, 64'h0);
    chk("rst_busy", busy, 1'b0);
    check_counts("rst");

    // Basic matching run, done 20 cycles after start
    start_run(1'b1, CT_OK);
    done_after(20);
    exp_runs++;
    chk("basic_valid", res_valid, 1'b1);
    chk("basic_ct", res_ct, CT_OK);
    chk("basic_match", res_match, 1'b1);
    chk("basic_to", res_timeout, 1'b0);
    check_counts("basic");
    handshake();

    // Mismatch
    start_run(1'b1, CT_BAD);
    done_after(5);
    exp_runs++; exp_errs++;
    chk("mm_ct", res_ct, CT_OK);
    chk("mm_match", res_match, 1'b0);
    chk("mm_to", res_timeout, 1'b0);
    check_counts("mm");
    handshake();

    // Compare disabled: bad expected value must not count as an error
    start_run(1'b0, CT_BAD);
    done_after(3);
    exp_runs++;
    chk("dis_ct", res_ct, CT_OK);
    chk("dis_match", res_match, 1'b0);
    check_counts("dis");
    handshake();

    // Timeout: valid TIMEOUT_CYCLES+1 cycles after start; match suppressed
    start_run(1'b1, CT_OK);
    cyc = 0;
    while (!res_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    exp_runs++; exp_errs++;
    chk("to_latency", cyc, 129);
    chk("to_flag", res_timeout, 1'b1);
    chk("to_ct", res_ct, 64'h0);
    chk("to_match", res_match, 1'b0);
    check_counts("to");
    handshake();

    // Backpressure with a stray req during HOLD
    start_run(1'b1, CT_OK);
    done_after(7);
    exp_runs++;
    held_ct = res_ct;
    chk("bp_ct", held_ct, CT_OK);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req = (i == 3);
      tick();
      if (!res_valid || res_ct !== held_ct || !res_match || core_start) stable = 1'b0;
    end
    req = 1'b0;
    chk("bp_stable", stable, 1'b1);
    check_counts("bp");
    handshake();
    start_run(1'b0, 64'h0);
    done_after(2);
    exp_runs++;
    chk("bp_next_valid", res_valid, 1'b1);
    handshake();
    check_counts("bp2");

    // Reset in WAIT, then a late core_done
    start_run(1'b1, CT_OK);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_runs = 0; exp_errs = 0;
    chk("rw_start", core_start, 1'b0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_valid", res_valid, 1'b0);
    chk("rw_ct", res_ct, 64'h0);
    chk("rw_match", res_match, 1'b0);
    chk("rw_to", res_timeout, 1'b0);
    check_counts("rw");
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("late_done_busy", busy, 1'b0);
    chk("late_done_valid", res_valid, 1'b0);
    check_counts("late");

    // core_done on the terminal-count cycle: done wins
    start_run(1'b1, CT_OK);
    done_after(128);
    exp_runs++;
    chk("tc_valid", res_valid, 1'b1);
    chk("tc_to", res_timeout, 1'b0);
    chk("tc_ct", res_ct, CT_OK);
    chk("tc_match", res_match, 1'b1);
    check_counts("tc");
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
